// File: rtl/mac_cfg_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mac_cfg_pkg : register map constants and bus FSM state type
// Rev 1.0
// ---------------------------------------------------------------------------
package mac_cfg_pkg;

  localparam logic [7:0] ADDR_REV          = 8'd0;
  localparam logic [7:0] ADDR_SCRATCH      = 8'd1;
  localparam logic [7:0] ADDR_CMD          = 8'd2;
  localparam logic [7:0] ADDR_MAC0         = 8'd3;
  localparam logic [7:0] ADDR_MAC1         = 8'd4;
  localparam logic [7:0] ADDR_RX_SEC_EMPTY = 8'd7;
  localparam logic [7:0] ADDR_RX_SEC_FULL  = 8'd8;
  localparam logic [7:0] ADDR_TX_SEC_EMPTY = 8'd9;
  localparam logic [7:0] ADDR_TX_SEC_FULL  = 8'd10;
  localparam logic [7:0] ADDR_RX_ALM_EMPTY = 8'd11;
  localparam logic [7:0] ADDR_RX_ALM_FULL  = 8'd12;
  localparam logic [7:0] ADDR_TX_ALM_EMPTY = 8'd13;
  localparam logic [7:0] ADDR_TX_ALM_FULL  = 8'd14;

  localparam int CMD_SW_RESET_BIT = 13;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } bus_state_t;

endpackage
`default_nettype wire

// File: rtl/mac_cfg_bus_fsm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mac_cfg_bus_fsm : rd/wr/busy slave handshake, request latch, commit strobe
// Rev 1.0
// ---------------------------------------------------------------------------
module mac_cfg_bus_fsm
  import mac_cfg_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  i_addr,
  input  logic [31:0] i_wdata,
  input  logic        i_rd,
  input  logic        i_wr,
  output logic        o_busy,
  output logic        o_commit,
  output logic        o_is_wr,
  output logic [7:0]  o_addr,
  output logic [31:0] o_wdata
);

  localparam logic [3:0] c_CNT_LOAD = 4'(WAIT_CYCLES - 1);

  bus_state_t  r_state;
  bus_state_t  w_next;
  logic [3:0]  r_cnt;
  logic [7:0]  r_addr;
  logic [31:0] r_wdata;
  logic        r_is_wr;
  logic        w_req;
  logic        w_busy;
  logic        w_commit;

  assign w_req = i_rd | i_wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Bus inputs are only looked at in IDLE; the latched copies drive the access.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= 4'd0;
      r_addr  <= 8'd0;
      r_wdata <= 32'd0;
      r_is_wr <= 1'b0;
    end else if (r_state == ST_IDLE && w_req) begin
      r_cnt   <= c_CNT_LOAD;
      r_addr  <= i_addr;
      r_wdata <= i_wdata;
      r_is_wr <= i_wr;
    end else if (r_state == ST_ACCESS && r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_busy   = 1'b0;
    w_commit = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_next = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        w_busy = 1'b1;
        if (r_cnt == 4'd0) begin
          w_commit = 1'b1;
          w_next   = ST_DONE;
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  assign o_busy   = w_busy;
  assign o_commit = w_commit;
  assign o_is_wr  = r_is_wr;
  assign o_addr   = r_addr;
  assign o_wdata  = r_wdata;

endmodule
`default_nettype wire

// File: rtl/mac_cfg_regs.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mac_cfg_regs : MAC configuration register file behind the rd/wr/busy bus
// Rev 1.0
// ---------------------------------------------------------------------------
module mac_cfg_regs
  import mac_cfg_pkg::*;
#(
  parameter int          WAIT_CYCLES = 2,
  parameter int          SEC_W       = 16,
  parameter int          ALM_W       = 8,
  parameter logic [31:0] REV         = 32'h0000_0100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       reg_addr,
  input  logic [31:0]      reg_writedata,
  input  logic             reg_rd,
  input  logic             reg_wr,
  output logic [31:0]      reg_readdata,
  output logic             reg_busy,
  output logic [47:0]      cfg_mac_addr,
  output logic [31:0]      cfg_cmd,
  output logic [SEC_W-1:0] cfg_rx_sec_empty,
  output logic [SEC_W-1:0] cfg_rx_sec_full,
  output logic [SEC_W-1:0] cfg_tx_sec_empty,
  output logic [SEC_W-1:0] cfg_tx_sec_full,
  output logic [ALM_W-1:0] cfg_rx_alm_empty,
  output logic [ALM_W-1:0] cfg_rx_alm_full,
  output logic [ALM_W-1:0] cfg_tx_alm_empty,
  output logic [ALM_W-1:0] cfg_tx_alm_full,
  output logic             cfg_sw_reset,
  output logic             cfg_update
);

  localparam logic [31:0] c_SW_RESET_MASK = 32'h1 << CMD_SW_RESET_BIT;

  logic        w_commit;
  logic        w_is_wr;
  logic [7:0]  w_addr;
  logic [31:0] w_wdata;
  logic [31:0] w_rdata;

  logic [31:0]      r_scratch;
  logic [31:0]      r_cmd;
  logic [31:0]      r_mac0;
  logic [15:0]      r_mac1;
  logic [SEC_W-1:0] r_rx_sec_empty;
  logic [SEC_W-1:0] r_rx_sec_full;
  logic [SEC_W-1:0] r_tx_sec_empty;
  logic [SEC_W-1:0] r_tx_sec_full;
  logic [ALM_W-1:0] r_rx_alm_empty;
  logic [ALM_W-1:0] r_rx_alm_full;
  logic [ALM_W-1:0] r_tx_alm_empty;
  logic [ALM_W-1:0] r_tx_alm_full;
  logic [31:0]      r_readdata;
  logic             r_sw_reset;
  logic             r_update;

  mac_cfg_bus_fsm #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_bus_fsm (
    .clk      (clk),
    .rst      (rst),
    .i_addr   (reg_addr),
    .i_wdata  (reg_writedata),
    .i_rd     (reg_rd),
    .i_wr     (reg_wr),
    .o_busy   (reg_busy),
    .o_commit (w_commit),
    .o_is_wr  (w_is_wr),
    .o_addr   (w_addr),
    .o_wdata  (w_wdata)
  );

  always_comb begin
    w_rdata = 32'd0;
    case (w_addr)
      ADDR_REV:          w_rdata = REV;
      ADDR_SCRATCH:      w_rdata = r_scratch;
      ADDR_CMD:          w_rdata = r_cmd;
      ADDR_MAC0:         w_rdata = r_mac0;
      ADDR_MAC1:         w_rdata = 32'(r_mac1);
      ADDR_RX_SEC_EMPTY: w_rdata = 32'(r_rx_sec_empty);
      ADDR_RX_SEC_FULL:  w_rdata = 32'(r_rx_sec_full);
      ADDR_TX_SEC_EMPTY: w_rdata = 32'(r_tx_sec_empty);
      ADDR_TX_SEC_FULL:  w_rdata = 32'(r_tx_sec_full);
      ADDR_RX_ALM_EMPTY: w_rdata = 32'(r_rx_alm_empty);
      ADDR_RX_ALM_FULL:  w_rdata = 32'(r_rx_alm_full);
      ADDR_TX_ALM_EMPTY: w_rdata = 32'(r_tx_alm_empty);
      ADDR_TX_ALM_FULL:  w_rdata = 32'(r_tx_alm_full);
      default:           w_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scratch      <= 32'd0;
      r_cmd          <= 32'd0;
      r_mac0         <= 32'd0;
      r_mac1         <= 16'd0;
      r_rx_sec_empty <= '0;
      r_rx_sec_full  <= '0;
      r_tx_sec_empty <= '0;
      r_tx_sec_full  <= '0;
      r_rx_alm_empty <= '0;
      r_rx_alm_full  <= '0;
      r_tx_alm_empty <= '0;
      r_tx_alm_full  <= '0;
      r_readdata     <= 32'd0;
      r_sw_reset     <= 1'b0;
      r_update       <= 1'b0;
    end else begin
      r_sw_reset <= 1'b0;
      r_update   <= 1'b0;
      if (w_commit) begin
        if (w_is_wr) begin
          // Every committed write pulses update, even to REV or unmapped space.
          r_update <= 1'b1;
          case (w_addr)
            ADDR_SCRATCH: r_scratch <= w_wdata;
            ADDR_CMD: begin
              r_cmd      <= w_wdata & ~c_SW_RESET_MASK;
              r_sw_reset <= w_wdata[CMD_SW_RESET_BIT];
            end
            ADDR_MAC0:         r_mac0         <= w_wdata;
            ADDR_MAC1:         r_mac1         <= w_wdata[15:0];
            ADDR_RX_SEC_EMPTY: r_rx_sec_empty <= w_wdata[SEC_W-1:0];
            ADDR_RX_SEC_FULL:  r_rx_sec_full  <= w_wdata[SEC_W-1:0];
            ADDR_TX_SEC_EMPTY: r_tx_sec_empty <= w_wdata[SEC_W-1:0];
            ADDR_TX_SEC_FULL:  r_tx_sec_full  <= w_wdata[SEC_W-1:0];
            ADDR_RX_ALM_EMPTY: r_rx_alm_empty <= w_wdata[ALM_W-1:0];
            ADDR_RX_ALM_FULL:  r_rx_alm_full  <= w_wdata[ALM_W-1:0];
            ADDR_TX_ALM_EMPTY: r_tx_alm_empty <= w_wdata[ALM_W-1:0];
            ADDR_TX_ALM_FULL:  r_tx_alm_full  <= w_wdata[ALM_W-1:0];
            default: begin
            end
          endcase
        end else begin
          r_readdata <= w_rdata;
        end
      end
    end
  end

  assign reg_readdata     = r_readdata;
  assign cfg_mac_addr     = {r_mac1, r_mac0};
  assign cfg_cmd          = r_cmd;
  assign cfg_rx_sec_empty = r_rx_sec_empty;
  assign cfg_rx_sec_full  = r_rx_sec_full;
  assign cfg_tx_sec_empty = r_tx_sec_empty;
  assign cfg_tx_sec_full  = r_tx_sec_full;
  assign cfg_rx_alm_empty = r_rx_alm_empty;
  assign cfg_rx_alm_full  = r_rx_alm_full;
  assign cfg_tx_alm_empty = r_tx_alm_empty;
  assign cfg_tx_alm_full  = r_tx_alm_full;
  assign cfg_sw_reset     = r_sw_reset;
  assign cfg_update       = r_update;

endmodule
`default_nettype wire

// File: tb/tb_mac_cfg_regs.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mac_cfg_regs : randomized bench for mac_cfg_regs with a cycle-level model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_mac_cfg_regs;

  localparam int          W     = 3;
  localparam int          SEC_W = 16;
  localparam int          ALM_W = 8;
  localparam logic [31:0] REV_V = 32'h0000_0100;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       reg_addr = 8'd0;
  logic [31:0]      reg_writedata = 32'd0;
  logic             reg_rd = 1'b0;
  logic             reg_wr = 1'b0;
  logic [31:0]      reg_readdata;
  logic             reg_busy;
  logic [47:0]      cfg_mac_addr;
  logic [31:0]      cfg_cmd;
  logic [SEC_W-1:0] cfg_rx_sec_empty, cfg_rx_sec_full, cfg_tx_sec_empty, cfg_tx_sec_full;
  logic [ALM_W-1:0] cfg_rx_alm_empty, cfg_rx_alm_full, cfg_tx_alm_empty, cfg_tx_alm_full;
  logic             cfg_sw_reset;
  logic             cfg_update;

  mac_cfg_regs #(
    .WAIT_CYCLES (W),
    .SEC_W       (SEC_W),
    .ALM_W       (ALM_W),
    .REV         (REV_V)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .reg_addr         (reg_addr),
    .reg_writedata    (reg_writedata),
    .reg_rd           (reg_rd),
    .reg_wr           (reg_wr),
    .reg_readdata     (reg_readdata),
    .reg_busy         (reg_busy),
    .cfg_mac_addr     (cfg_mac_addr),
    .cfg_cmd          (cfg_cmd),
    .cfg_rx_sec_empty (cfg_rx_sec_empty),
    .cfg_rx_sec_full  (cfg_rx_sec_full),
    .cfg_tx_sec_empty (cfg_tx_sec_empty),
    .cfg_tx_sec_full  (cfg_tx_sec_full),
    .cfg_rx_alm_empty (cfg_rx_alm_empty),
    .cfg_rx_alm_full  (cfg_rx_alm_full),
    .cfg_tx_alm_empty (cfg_tx_alm_empty),
    .cfg_tx_alm_full  (cfg_tx_alm_full),
    .cfg_sw_reset     (cfg_sw_reset),
    .cfg_update       (cfg_update)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_upd    = 0;
  int n_swr    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got timeout expected busy edge (cycle %0d)", name, cyc);
  endtask

  // ---------------- behavioural model ----------------
  // Timing rule: a request accepted in cycle A makes busy high in A+1..A+W,
  // the result visible in A+W+1, and the next request acceptable from A+W+2.
  logic [31:0] m_reg [0:15];
  logic [31:0] m_rdata;
  int          acc;
  bit          m_wr;
  logic [7:0]  m_addr;
  logic [31:0] m_data;
  bit          e_busy, e_upd, e_swr;
  bit          model_ok = 1'b0;

  function automatic logic [31:0] m_read(input logic [7:0] a);
    if (a == 8'd0) return REV_V;
    if (a <= 8'd4 || (a >= 8'd7 && a <= 8'd14)) return m_reg[a[3:0]];
    return 32'd0;
  endfunction

  task automatic m_write(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] sec_mask;
    logic [31:0] alm_mask;
    sec_mask = 32'((64'd1 << SEC_W) - 64'd1);
    alm_mask = 32'((64'd1 << ALM_W) - 64'd1);
    if (a == 8'd1 || a == 8'd3)          m_reg[a[3:0]] = d;
    else if (a == 8'd2)                  m_reg[2] = d & ~(32'd1 << 13);
    else if (a == 8'd4)                  m_reg[4] = d & 32'h0000_FFFF;
    else if (a >= 8'd7 && a <= 8'd10)    m_reg[a[3:0]] = d & sec_mask;
    else if (a >= 8'd11 && a <= 8'd14)   m_reg[a[3:0]] = d & alm_mask;
  endtask

  initial begin
    acc = -1000;
    forever begin
      @(posedge clk);
      if (rst) begin
        acc = -1000;
        for (int i = 0; i < 16; i++) m_reg[i] = 32'd0;
        m_rdata = 32'd0;
        m_wr    = 1'b0;
      end else if (cyc >= acc + W + 2 && (reg_rd || reg_wr)) begin
        acc    = cyc;
        m_wr   = reg_wr;
        m_addr = reg_addr;
        m_data = reg_writedata;
      end else if (cyc == acc + W) begin
        if (m_wr) m_write(m_addr, m_data);
        else      m_rdata = m_read(m_addr);
      end
      e_busy   = (cyc + 1 >= acc + 1) && (cyc + 1 <= acc + W);
      e_upd    = (cyc + 1 == acc + W + 1) && m_wr;
      e_swr    = e_upd && (m_addr == 8'd2) && m_data[13];
      cyc++;
      model_ok = 1'b1;
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (model_ok) begin
        chk("busy",         {63'd0, reg_busy},     {63'd0, e_busy});
        chk("readdata",     64'(reg_readdata),     64'(m_rdata));
        chk("update",       {63'd0, cfg_update},   {63'd0, e_upd});
        chk("sw_reset",     {63'd0, cfg_sw_reset}, {63'd0, e_swr});
        chk("mac_addr",     64'(cfg_mac_addr),     64'({m_reg[4][15:0], m_reg[3]}));
        chk("cmd",          64'(cfg_cmd),          64'(m_reg[2]));
        chk("rx_sec_empty", 64'(cfg_rx_sec_empty), 64'(m_reg[7]));
        chk("rx_sec_full",  64'(cfg_rx_sec_full),  64'(m_reg[8]));
        chk("tx_sec_empty", 64'(cfg_tx_sec_empty), 64'(m_reg[9]));
        chk("tx_sec_full",  64'(cfg_tx_sec_full),  64'(m_reg[10]));
        chk("rx_alm_empty", 64'(cfg_rx_alm_empty), 64'(m_reg[11]));
        chk("rx_alm_full",  64'(cfg_rx_alm_full),  64'(m_reg[12]));
        chk("tx_alm_empty", 64'(cfg_tx_alm_empty), 64'(m_reg[13]));
        chk("tx_alm_full",  64'(cfg_tx_alm_full),  64'(m_reg[14]));
        if (cfg_update)   n_upd++;
        if (cfg_sw_reset) n_swr++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_busy(input logic lvl, input bit scramble, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (scramble) begin
        reg_addr      = 8'($urandom);
        reg_writedata = $urandom;
      end
      @(negedge clk);
      if (reg_busy === lvl) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now(lvl ? "busy_rise" : "busy_fall");
  endtask

  // Leaves the request lines as driven; returns at the negedge of the DONE cycle.
  task automatic access(input bit rd, input bit wr, input logic [7:0] a,
                        input logic [31:0] d, input bit scramble);
    bit ok;
    reg_rd        = rd;
    reg_wr        = wr;
    reg_addr      = a;
    reg_writedata = d;
    wait_busy(1'b1, 1'b0, ok);
    if (ok) wait_busy(1'b0, scramble, ok);
  endtask

  task automatic idle(input int n);
    reg_rd = 1'b0;
    reg_wr = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic rd_expect(input logic [7:0] a, input logic [31:0] exp, input string name);
    access(1'b1, 1'b0, a, 32'd0, 1'b0);
    idle(1);
    chk(name, 64'(reg_readdata), 64'(exp));
  endtask

  logic [7:0]  init_a [0:10] = '{8'd3, 8'd4, 8'd9, 8'd10, 8'd7, 8'd8, 8'd11, 8'd12, 8'd13, 8'd14, 8'd2};
  logic [31:0] init_d [0:10] = '{32'h0615_0910, 32'h2019, 32'd500, 32'd200, 32'd4000, 32'd0,
                                 32'd8, 32'd8, 32'd8, 32'd3, 32'h0400_0033};

  initial begin
    int  u0;
    bit  ok;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("reset_busy",     {63'd0, reg_busy}, 64'd0);
    chk("reset_readdata", 64'(reg_readdata), 64'd0);
    chk("reset_mac",      64'(cfg_mac_addr), 64'd0);
    chk("reset_cmd",      64'(cfg_cmd),      64'd0);

    // Init sequence with wr held across all 11 writes.
    u0 = n_upd;
    for (int i = 0; i < 11; i++) access(1'b0, 1'b1, init_a[i], init_d[i], 1'b0);
    idle(2);
    chk("init_mac",          64'(cfg_mac_addr),     64'h2019_0615_0910);
    chk("init_tx_sec_empty", 64'(cfg_tx_sec_empty), 64'd500);
    chk("init_rx_sec_empty", 64'(cfg_rx_sec_empty), 64'd4000);
    chk("init_tx_alm_full",  64'(cfg_tx_alm_full),  64'd3);
    chk("init_cmd",          64'(cfg_cmd),          64'h0400_0033);
    chk("init_updates",      64'(n_upd - u0),       64'd11);

    // Handshake timing with wr held: busy T+1..T+3, low T+4,T+5, high T+6.
    reg_wr = 1'b1; reg_addr = 8'd1; reg_writedata = 32'h1;
    @(negedge clk); chk("hs_t1", {63'd0, reg_busy}, 64'd1);
    @(negedge clk); chk("hs_t2", {63'd0, reg_busy}, 64'd1);
    @(negedge clk); chk("hs_t3", {63'd0, reg_busy}, 64'd1);
    @(negedge clk); chk("hs_t4", {63'd0, reg_busy}, 64'd0);
    @(negedge clk); chk("hs_t5", {63'd0, reg_busy}, 64'd0);
    @(negedge clk); chk("hs_t6", {63'd0, reg_busy}, 64'd1);
    wait_busy(1'b0, 1'b0, ok);
    idle(1);

    rd_expect(8'd0, 32'h0000_0100, "read_rev");
    access(1'b0, 1'b1, 8'd1, 32'hDEAD_BEEF, 1'b0); idle(1);
    rd_expect(8'd1, 32'hDEAD_BEEF, "read_scratch");
    rd_expect(8'd5, 32'd0, "read_unmapped");
    access(1'b0, 1'b1, 8'd4, 32'hFFFF_1234, 1'b0); idle(1);
    rd_expect(8'd4, 32'h0000_1234, "read_mac1_trunc");

    u0 = n_swr;
    access(1'b0, 1'b1, 8'd2, 32'h0000_2003, 1'b0); idle(1);
    chk("sw_reset_pulses", 64'(n_swr - u0), 64'd1);
    chk("cmd_after_swr",   64'(cfg_cmd),    64'h3);
    rd_expect(8'd2, 32'h0000_0003, "read_cmd");

    // rd and wr together behave as a write; readdata keeps the last read (cmd = 3).
    access(1'b1, 1'b1, 8'd1, 32'h55, 1'b0); idle(1);
    chk("both_readdata", 64'(reg_readdata), 64'h3);
    rd_expect(8'd1, 32'h55, "read_scratch_55");

    // Reset during ACCESS aborts the write.
    u0 = n_upd;
    reg_wr = 1'b1; reg_addr = 8'd3; reg_writedata = 32'h1234_5678;
    wait_busy(1'b1, 1'b0, ok);
    rst = 1'b1; reg_wr = 1'b0;
    @(negedge clk);
    chk("rst_abort_busy", {63'd0, reg_busy},     64'd0);
    chk("rst_abort_mac0", 64'(cfg_mac_addr[31:0]), 64'd0);
    rst = 1'b0;
    idle(W + 3);
    chk("rst_abort_update", 64'(n_upd - u0), 64'd0);

    // Randomized traffic; the per-cycle compare covers it.
    for (int i = 0; i < 300; i++) begin
      int          op;
      int          gap;
      logic [7:0]  a;
      op  = $urandom_range(0, 2);
      a   = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(0, 15));
      access(op != 1, op != 0, a, $urandom, bit'($urandom_range(0, 1)));
      gap = $urandom_range(0, 3);
      if (gap > 0) idle(gap);
    end
    idle(W + 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected completion (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
